// File: rtl/tail_light_sequencer_pkg.sv
// Shared constants for the tail-light path: request codes from the state
// decider, sequencer mode encodings, lamp index ranges and small helpers.
package tail_light_sequencer_pkg;

  // Lighting request codes (bit 2 = brake, bit 3 = hazard)
  localparam logic [3:0] ST_IDLE       = 4'b0000;
  localparam logic [3:0] ST_IDLE_ALT   = 4'b0010;
  localparam logic [3:0] ST_RIGHT      = 4'b0001;
  localparam logic [3:0] ST_LEFT       = 4'b0011;
  localparam logic [3:0] ST_BRAKE      = 4'b0100;
  localparam logic [3:0] ST_BRAKE_ALT  = 4'b0110;
  localparam logic [3:0] ST_BRAKE_R    = 4'b0101;
  localparam logic [3:0] ST_BRAKE_L    = 4'b0111;
  localparam logic [3:0] ST_HAZARD     = 4'b1000;

  // Sequencer mode encodings
  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_TURN_L = 2'd1;
  localparam logic [1:0] MODE_TURN_R = 2'd2;
  localparam logic [1:0] MODE_HAZARD = 2'd3;

  // Lamp index ranges on the 10-bit LEDR bus
  localparam int LEFT_HI  = 9;
  localparam int LEFT_LO  = 7;
  localparam int CTR_HI   = 6;
  localparam int CTR_LO   = 3;
  localparam int RIGHT_HI = 2;
  localparam int RIGHT_LO = 0;

  // Map a request code to a sequencer mode; brake is carried separately.
  function automatic logic [1:0] decode_mode(input logic [3:0] code);
    if (code[3])
      return MODE_HAZARD;
    else if (!code[0])
      return MODE_IDLE;
    else if (code[1])
      return MODE_TURN_L;
    else
      return MODE_TURN_R;
  endfunction

  // Left group grows outward from led[7] toward led[9].
  function automatic logic [2:0] seq_left(input logic [1:0] ph);
    case (ph)
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      2'd3:    return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Right group grows outward from led[2] toward led[0].
  function automatic logic [2:0] seq_right(input logic [1:0] ph);
    case (ph)
      2'd1:    return 3'b100;
      2'd2:    return 3'b110;
      2'd3:    return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tail_light_sequencer_lamp_decode.sv
// Combinational lamp pattern generator: mode, phase and brake flag in,
// 10-bit lamp drive out.
module lamp_decode
  import tail_light_sequencer_pkg::*;
#(
  parameter bit HAZ_CENTER = 1'b0
) (
  input  logic [1:0] mode,
  input  logic [1:0] phase,
  input  logic       brake,
  output logic [9:0] led
);

  logic [2:0] left_grp;
  logic [2:0] right_grp;
  logic [3:0] centre_grp;
  logic       flash;

  assign flash = (phase == 2'd1);

  // Select each lamp group from the current mode, phase and brake flag.
  always_comb begin
    left_grp   = {3{brake}};
    right_grp  = {3{brake}};
    centre_grp = {4{brake}};
    case (mode)
      MODE_TURN_L: left_grp  = seq_left(phase);
      MODE_TURN_R: right_grp = seq_right(phase);
      MODE_HAZARD: begin
        left_grp  = {3{flash}};
        right_grp = {3{flash}};
        if (HAZ_CENTER)
          centre_grp = {4{flash}};
      end
      default: ;
    endcase
    led                    = '0;
    led[LEFT_HI:LEFT_LO]   = left_grp;
    led[CTR_HI:CTR_LO]     = centre_grp;
    led[RIGHT_HI:RIGHT_LO] = right_grp;
  end

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: decodes the lighting request, keeps the mode, brake
// flag and phase counter, and registers the lamp drive from lamp_decode.
module tail_light_sequencer
  import tail_light_sequencer_pkg::*;
#(
  parameter bit HAZ_CENTER = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] state,
  output logic [9:0] led,
  output logic [1:0] phase,
  output logic       seq_done
);

  logic [1:0] mode_p0;
  logic       brake_p0;
  logic [1:0] phase_p0;
  logic       done_p0;
  logic [9:0] led_p0;
  logic       mode_chg;

  logic [1:0] mode_p1;
  logic       brake_p1;
  logic [1:0] phase_p1;
  logic       done_p1;
  logic [9:0] led_p1;

  assign mode_p0  = decode_mode(state);
  assign brake_p0 = state[2];
  assign mode_chg = (mode_p0 != mode_p1);

  // Next phase and wrap pulse; a mode change restarts at phase 0 and eats any coincident tick.
  always_comb begin
    phase_p0 = phase_p1;
    done_p0  = 1'b0;
    if (mode_chg) begin
      phase_p0 = 2'd0;
    end else begin
      case (mode_p1)
        MODE_TURN_L, MODE_TURN_R: begin
          if (tick) begin
            phase_p0 = phase_p1 + 2'd1;
            done_p0  = (phase_p1 == 2'd3);
          end
        end
        MODE_HAZARD: begin
          if (tick)
            phase_p0 = (phase_p1 == 2'd0) ? 2'd1 : 2'd0;
        end
        default: phase_p0 = 2'd0;
      endcase
    end
  end

  // Lamp pattern is decoded from next-state values so led lands one clock after the input.
  lamp_decode #(
    .HAZ_CENTER(HAZ_CENTER)
  ) u_lamp_decode (
    .mode  (mode_p0),
    .phase (phase_p0),
    .brake (brake_p0),
    .led   (led_p0)
  );

  // Mode, brake, phase and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_p1  <= MODE_IDLE;
      brake_p1 <= 1'b0;
      phase_p1 <= 2'd0;
      done_p1  <= 1'b0;
      led_p1   <= '0;
    end else begin
      mode_p1  <= mode_p0;
      brake_p1 <= brake_p0;
      phase_p1 <= phase_p0;
      done_p1  <= done_p0;
      led_p1   <= led_p0;
    end
  end

  assign led      = led_p1;
  assign phase    = phase_p1;
  assign seq_done = done_p1;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed bench for tail_light_sequencer; two instances cover both
// HAZ_CENTER settings from the same stimulus.
module tb_tail_light_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] state = 4'b0000;

  logic [9:0] led0, led1;
  logic [1:0] phase0, phase1;
  logic       done0, done1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tail_light_sequencer #(.HAZ_CENTER(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .state(state),
    .led(led0), .phase(phase0), .seq_done(done0)
  );

  tail_light_sequencer #(.HAZ_CENTER(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .state(state),
    .led(led1), .phase(phase1), .seq_done(done1)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Apply inputs, clock once, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic t, input logic [3:0] s);
    rst   = r;
    tick  = t;
    state = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    // Reset with a live request and tick present
    step(1'b1, 1'b1, 4'b0011);
    step(1'b1, 1'b1, 4'b0011);
    chk("rst_led",   led0, 10'b0);
    chk("rst_phase", {8'b0, phase0}, 10'd0);
    chk("rst_done",  {9'b0, done0}, 10'd0);

    // Left turn: enter, then five ticks
    step(1'b0, 1'b0, 4'b0011);
    chk("left_enter", led0, 10'b0000000000);
    step(1'b0, 1'b1, 4'b0011);
    chk("left_t1", led0, 10'b0010000000);
    step(1'b0, 1'b1, 4'b0011);
    chk("left_t2", led0, 10'b0110000000);
    chk("left_t2_done", {9'b0, done0}, 10'd0);
    step(1'b0, 1'b1, 4'b0011);
    chk("left_t3", led0, 10'b1110000000);
    step(1'b0, 1'b1, 4'b0011);
    chk("left_t4", led0, 10'b0000000000);
    chk("left_t4_done", {9'b0, done0}, 10'd1);
    step(1'b0, 1'b0, 4'b0011);
    chk("left_done_drop", {9'b0, done0}, 10'd0);
    step(1'b0, 1'b1, 4'b0011);
    chk("left_t5", led0, 10'b0010000000);

    // Tick held high: each high cycle advances
    step(1'b0, 1'b1, 4'b0011);
    chk("hold_c1", led0, 10'b0110000000);
    step(1'b0, 1'b1, 4'b0011);
    chk("hold_c2", led0, 10'b1110000000);
    chk("hold_phase", {8'b0, phase0}, 10'd3);

    // Reset at phase 3 with a tick that would otherwise wrap
    step(1'b1, 1'b1, 4'b0011);
    chk("rstmid_led",   led0, 10'b0);
    chk("rstmid_phase", {8'b0, phase0}, 10'd0);
    chk("rstmid_done",  {9'b0, done0}, 10'd0);

    // Resume, advance to phase 2, then switch to right with a coincident tick
    step(1'b0, 1'b0, 4'b0011);
    chk("resume_phase", {8'b0, phase0}, 10'd0);
    step(1'b0, 1'b1, 4'b0011);
    step(1'b0, 1'b1, 4'b0011);
    chk("dir_pre", led0, 10'b0110000000);
    step(1'b0, 1'b1, 4'b0001);
    chk("dir_led",   led0, 10'b0000000000);
    chk("dir_phase", {8'b0, phase0}, 10'd0);
    step(1'b0, 1'b1, 4'b0001);
    chk("dir_t1", led0, 10'b0000000100);

    // Brake + right from idle
    step(1'b0, 1'b0, 4'b0000);
    chk("idle_off", led0, 10'b0);
    step(1'b0, 1'b0, 4'b0101);
    chk("bkr_enter", led0, 10'b1111111000);
    step(1'b0, 1'b1, 4'b0101);
    chk("bkr_t1", led0, 10'b1111111100);
    step(1'b0, 1'b1, 4'b0101);
    chk("bkr_t2", led0, 10'b1111111110);
    step(1'b0, 1'b1, 4'b0101);
    chk("bkr_t3", led0, 10'b1111111111);

    // Idle brake, then idle off
    step(1'b0, 1'b0, 4'b0100);
    chk("idle_brake", led0, 10'b1111111111);
    step(1'b0, 1'b0, 4'b0010);
    chk("idle_clear", led0, 10'b0000000000);

    // Hazard on both centre options
    step(1'b0, 1'b0, 4'b1000);
    chk("haz_enter0", led0, 10'b0);
    chk("haz_enter1", led1, 10'b0);
    step(1'b0, 1'b1, 4'b1000);
    chk("haz_t1_c0", led0, 10'b1110000111);
    chk("haz_t1_c1", led1, 10'b1111111111);
    chk("haz_t1_done", {9'b0, done0}, 10'd0);
    step(1'b0, 1'b1, 4'b1000);
    chk("haz_t2_c0", led0, 10'b0);
    chk("haz_t2_c1", led1, 10'b0);
    step(1'b0, 1'b1, 4'b1000);
    chk("haz_t3_c0", led0, 10'b1110000111);
    chk("haz_t3_c1", led1, 10'b1111111111);
    step(1'b0, 1'b1, 4'b1000);
    chk("haz_t4_c0", led0, 10'b0);
    chk("haz_t4_phase", {8'b0, phase1}, 10'd0);

    // Hazard with brake: centre follows brake only without HAZ_CENTER
    step(1'b0, 1'b0, 4'b1100);
    chk("hazbk_c0", led0, 10'b0001111000);
    chk("hazbk_c1", led1, 10'b0000000000);
    step(1'b0, 1'b1, 4'b1100);
    chk("hazbk_t_c0", led0, 10'b1111111111);
    chk("hazbk_t_c1", led1, 10'b1111111111);

    // Reset mid-hazard
    step(1'b1, 1'b1, 4'b1100);
    chk("rsthaz_c0", led0, 10'b0);
    chk("rsthaz_c1", led1, 10'b0);
    chk("rsthaz_phase", {8'b0, phase1}, 10'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
